// File: rtl/cpu6_pkg.sv
// cpu6_pkg: shared address widths and FSM states for the cpu6 MMU.
package cpu6_pkg;
   localparam int LADDR_W    = 16;
   localparam int PADDR_W    = 18;
   localparam int FRAME_W    = 7;
   localparam int PAGE_SHIFT = 11;
   typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
endpackage

// File: rtl/cpu6_mmu_if.sv
// cpu6_mmu_if: CPU request, page-table update and translated-access signals of the MMU.
interface cpu6_mmu_if;
   logic                           req_valid;
   logic [cpu6_pkg::LADDR_W-1:0]   req_addr;
   logic                           req_write;
   logic                           req_ready;
   logic                           ptb_load;
   logic [2:0]                     ptb_in;
   logic                           pt_write;
   logic [4:0]                     pt_index;
   logic [7:0]                     pt_data;
   logic                           phys_valid;
   logic [cpu6_pkg::PADDR_W-1:0]   phys_addr;
   logic                           phys_write;
   logic                           fault;
   logic [cpu6_pkg::LADDR_W-1:0]   fault_addr;
   logic                           fault_clear;
   modport master (
      output req_valid, req_addr, req_write, ptb_load, ptb_in, pt_write, pt_index, pt_data, fault_clear,
      input  req_ready, phys_valid, phys_addr, phys_write, fault, fault_addr
   );
   modport slave (
      input  req_valid, req_addr, req_write, ptb_load, ptb_in, pt_write, pt_index, pt_data, fault_clear,
      output req_ready, phys_valid, phys_addr, phys_write, fault, fault_addr
   );
endinterface

// File: rtl/mmu_page_ram.sv
// mmu_page_ram: page-table entry storage, synchronous write and combinational read.
module mmu_page_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [7:0]    rd_data
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];
endmodule

// File: rtl/cpu6_mmu.sv
// cpu6_mmu: paged MMU translating 16-bit CPU addresses into 18-bit physical addresses.
// Define CPU6_MMU_WRITE_PROTECT_EN to trap writes to write-protected pages.
module cpu6_mmu
   import cpu6_pkg::*;
#(
   parameter int INIT_IDENTITY = 1,
   parameter int PT_TABLES     = 8
) (
   input logic       clock,
   input logic       reset,
   cpu6_mmu_if.slave bus
);
   localparam int ENTRIES = PT_TABLES * 32;
   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int PAGE_W  = LADDR_W - PAGE_SHIFT;

   state_t           state;
   logic [7:0]       cnt;
   logic [2:0]       ptb;
   logic [7:0]       entry;
   logic [7:0]       wr_data;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             in_init;
   logic             wr_en;
   logic             accept;
   logic             wp_hit;
   logic             pass;

   assign in_init       = state == INIT;
   assign bus.req_ready = state == RUN;
   assign accept        = bus.req_valid && state == RUN;
   assign pass          = accept && !wp_hit;
   assign rd_idx        = IDX_W'({ptb, bus.req_addr[LADDR_W-1:PAGE_SHIFT]});
   // The power-up sweep owns the write port, so CPU table writes are locked out until it ends.
   assign wr_en   = in_init || bus.pt_write;
   assign wr_idx  = in_init ? IDX_W'(cnt) : IDX_W'({ptb, bus.pt_index});
   assign wr_data = in_init ? (INIT_IDENTITY != 0 ? 8'(cnt[PAGE_W-1:0]) : 8'h00) : bus.pt_data;

   mmu_page_ram #(.DEPTH(ENTRIES), .AW(IDX_W)) ram (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (entry)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= INIT;
         cnt            <= '0;
         ptb            <= '0;
         bus.phys_valid <= 1'b0;
         bus.phys_addr  <= '0;
         bus.phys_write <= 1'b0;
      end else begin
         bus.phys_valid <= pass;
         if (pass) begin
            bus.phys_addr  <= {entry[FRAME_W-1:0], bus.req_addr[PAGE_SHIFT-1:0]};
            bus.phys_write <= bus.req_write;
         end
         if (!in_init && bus.ptb_load) ptb <= bus.ptb_in;
         if (in_init) cnt <= cnt + 8'd1;
         if (in_init && cnt == 8'(ENTRIES - 1)) state <= RUN;
         else if (wp_hit) state <= FAULT;
         else if (state == FAULT && bus.fault_clear) state <= RUN;
      end
   end

`ifdef CPU6_MMU_WRITE_PROTECT_EN
   assign wp_hit = accept && bus.req_write && entry[7];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.fault      <= 1'b0;
         bus.fault_addr <= '0;
      end else if (wp_hit) begin
         bus.fault      <= 1'b1;
         bus.fault_addr <= bus.req_addr;
      end else if (bus.fault_clear) begin
         bus.fault <= 1'b0;
      end
   end
`else
   logic unused;
   assign wp_hit         = 1'b0;
   assign bus.fault      = 1'b0;
   assign bus.fault_addr = '0;
   assign unused         = ^{bus.fault_clear, entry[7]};
`endif
endmodule

// File: tb/tb_cpu6_mmu.sv
// tb_cpu6_mmu: table-driven, directed and random checks of cpu6_mmu against a page-table model.
module tb_cpu6_mmu;
`ifdef CPU6_MMU_WRITE_PROTECT_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0]  ptb;
      logic [4:0]  idx;
      logic [7:0]  data;
      logic [15:0] addr;
      logic [17:0] exp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          n;
   logic [7:0]  ref_mem [256];
   logic [2:0]  m_ptb;
   int          m_left;
   bit          m_fault;
   logic        e_valid, e_write, e_fault;
   logic [17:0] e_addr;
   logic [15:0] e_faddr;
   vec_t        vecs [4];
   logic [15:0] seq_addr [4];

   cpu6_mmu_if bus();

   cpu6_mmu dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.req_valid   = 1'b0;
      bus.req_addr    = '0;
      bus.req_write   = 1'b0;
      bus.ptb_load    = 1'b0;
      bus.ptb_in      = '0;
      bus.pt_write    = 1'b0;
      bus.pt_index    = '0;
      bus.pt_data     = '0;
      bus.fault_clear = 1'b0;
   endtask

   // Model view after power-up: every table maps page p to frame p, nothing protected.
   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i % 32);
      m_ptb   = '0;
      m_left  = 256;
      m_fault = 1'b0;
      e_valid = 1'b0;
      e_write = 1'b0;
      e_fault = 1'b0;
      e_addr  = '0;
      e_faddr = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_phys_valid", 32'(bus.phys_valid), 32'd0);
      chk("rst_phys_addr", 32'(bus.phys_addr), 32'd0);
      chk("rst_phys_write", 32'(bus.phys_write), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_fault_addr", 32'(bus.fault_addr), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      clear_inputs();
   endtask

   task automatic step();
      logic [7:0] ent;
      logic       acc, wp;
      e_valid = 1'b0;
      if (m_left > 0) begin
         m_left--;
      end else begin
         acc = bus.req_valid && !m_fault;
         ent = ref_mem[{m_ptb, bus.req_addr[15:11]}];
         wp  = WP_EN && acc && bus.req_write && ent[7];
         e_valid = acc && !wp;
         if (e_valid) begin
            e_addr  = {ent[6:0], bus.req_addr[10:0]};
            e_write = bus.req_write;
         end
         if (wp) begin
            m_fault = 1'b1;
            e_fault = 1'b1;
            e_faddr = bus.req_addr;
         end else if (bus.fault_clear) begin
            m_fault = 1'b0;
            e_fault = 1'b0;
         end
         if (bus.pt_write) ref_mem[{m_ptb, bus.pt_index}] = bus.pt_data;
         if (bus.ptb_load) m_ptb = bus.ptb_in;
      end
      @(posedge clock);
      #1;
      chk("req_ready", 32'(bus.req_ready), 32'(m_left == 0 && !m_fault));
      chk("phys_valid", 32'(bus.phys_valid), 32'(e_valid));
      chk("phys_addr", 32'(bus.phys_addr), 32'(e_addr));
      chk("phys_write", 32'(bus.phys_write), 32'(e_write));
      chk("fault", 32'(bus.fault), 32'(e_fault));
      chk("fault_addr", 32'(bus.fault_addr), 32'(e_faddr));
      clear_inputs();
   endtask

   task automatic random_inputs();
      bus.req_valid   = 1'($urandom);
      bus.req_addr    = 16'($urandom);
      bus.req_write   = 1'($urandom);
      bus.pt_write    = 1'($urandom_range(3) == 0);
      bus.pt_index    = 5'($urandom);
      bus.pt_data     = 8'($urandom);
      bus.ptb_load    = 1'($urandom_range(7) == 0);
      bus.ptb_in      = 3'($urandom);
      bus.fault_clear = 1'($urandom_range(3) == 0);
   endtask

   task automatic wait_init(output int cycles);
      cycles = 0;
      while (!bus.req_ready && cycles < 400) begin
         random_inputs();
         step();
         cycles++;
      end
   endtask

   task automatic request(input logic [15:0] addr, input logic wr);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_write = wr;
   endtask

   initial begin
      vecs[0] = '{3'd3, 5'h1E, 8'h55, 16'hF0AB, 18'h2A8AB};
      vecs[1] = '{3'd1, 5'h00, 8'h7F, 16'h0123, 18'h3F923};
      vecs[2] = '{3'd7, 5'h1F, 8'h01, 16'hFFFF, 18'h00FFF};
      vecs[3] = '{3'd0, 5'h05, 8'h00, 16'h2A00, 18'h00200};
      seq_addr[0] = 16'h0000;
      seq_addr[1] = 16'h0800;
      seq_addr[2] = 16'h1000;
      seq_addr[3] = 16'h1800;
      clear_inputs();
      #1;
      do_reset();
      wait_init(n);
      chk("init_cycles", 32'(n), 32'd256);
      request(16'h1234, 1'b0);
      step();
      chk("first_read", 32'(bus.phys_addr), 32'h01234);
      for (int i = 0; i < 4; i++) begin
         request(seq_addr[i], 1'b0);
         step();
         chk("b2b_valid", 32'(bus.phys_valid), 32'd1);
         chk("b2b_addr", 32'(bus.phys_addr), 32'(seq_addr[i]));
      end
      step();
      chk("hold_valid", 32'(bus.phys_valid), 32'd0);
      chk("hold_addr", 32'(bus.phys_addr), 32'h01800);
      for (int i = 0; i < 4; i++) begin
         bus.ptb_load = 1'b1;
         bus.ptb_in   = vecs[i].ptb;
         step();
         bus.pt_write = 1'b1;
         bus.pt_index = vecs[i].idx;
         bus.pt_data  = vecs[i].data;
         step();
         request(vecs[i].addr, 1'b0);
         step();
         chk("vec_phys", 32'(bus.phys_addr), 32'(vecs[i].exp));
      end
      bus.pt_write = 1'b1;
      bus.pt_index = 5'd2;
      bus.pt_data  = 8'h10;
      request(16'h1000, 1'b0);
      step();
      chk("wr_same_cycle", 32'(bus.phys_addr), 32'h01000);
      request(16'h1000, 1'b0);
      step();
      chk("wr_next_cycle", 32'(bus.phys_addr), 32'h08000);
      bus.ptb_load = 1'b1;
      bus.ptb_in   = 3'd5;
      bus.pt_write = 1'b1;
      bus.pt_index = 5'd1;
      bus.pt_data  = 8'h22;
      request(16'h0800, 1'b0);
      step();
      chk("ptb_old_base", 32'(bus.phys_addr), 32'h00800);
      request(16'h0800, 1'b0);
      step();
      chk("ptb_new_base", 32'(bus.phys_addr), 32'h00800);
      bus.ptb_load = 1'b1;
      bus.ptb_in   = 3'd0;
      request(16'h0800, 1'b0);
      step();
      chk("ptb_back_old", 32'(bus.phys_addr), 32'h00800);
      request(16'h0800, 1'b0);
      step();
      chk("wr_old_base", 32'(bus.phys_addr), 32'h11000);
      bus.pt_write = 1'b1;
      bus.pt_index = 5'd0;
      bus.pt_data  = 8'h80;
      step();
      request(16'h0010, 1'b1);
      step();
`ifdef CPU6_MMU_WRITE_PROTECT_EN
      chk("wp_valid", 32'(bus.phys_valid), 32'd0);
      chk("wp_fault", 32'(bus.fault), 32'd1);
      chk("wp_fault_addr", 32'(bus.fault_addr), 32'h0010);
      chk("wp_ready", 32'(bus.req_ready), 32'd0);
      bus.fault_clear = 1'b1;
      step();
      chk("wp_clear_ready", 32'(bus.req_ready), 32'd1);
      chk("wp_clear_fault", 32'(bus.fault), 32'd0);
`else
      chk("nowp_valid", 32'(bus.phys_valid), 32'd1);
      chk("nowp_addr", 32'(bus.phys_addr), 32'h00010);
      chk("nowp_fault", 32'(bus.fault), 32'd0);
`endif
      for (int i = 0; i < 400; i++) begin
         random_inputs();
         step();
      end
      bus.fault_clear = 1'b1;
      step();
      request(16'($urandom), 1'b0);
      step();
      chk("inflight_valid", 32'(bus.phys_valid), 32'd1);
      do_reset();
      for (int i = 0; i < 100; i++) begin
         random_inputs();
         step();
      end
      chk("mid_init_ready", 32'(bus.req_ready), 32'd0);
      do_reset();
      wait_init(n);
      chk("reinit_cycles", 32'(n), 32'd256);
      request(16'h1234, 1'b0);
      step();
      chk("reinit_read", 32'(bus.phys_addr), 32'h01234);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
